ip_tx: RTL and testbench
========================

# ip_tx

Byte-serial IPv4 transmitter, the transmit-side counterpart of the IP receive path. Takes a transport segment (UDP/TCP) from the layer above, builds a fixed 20-byte IPv4 header (no options, DF set, no fragmentation) with a computed header checksum, and streams header plus payload to the MAC transmit layer under ready backpressure. The source address is always `FPGA_IP`. Segments whose length cannot fit one unfragmented datagram are rejected.

## Interface
- TTL, 8'd64, Time To Live placed in byte 8.
- MAX_SEG_LEN, 16'd1480, largest accepted segment length in bytes (MTU 1500 minus 20).
- i_sys_clk  in  1  system clock.
- i_rstn  in  1  reset, asynchronous, active-low.
- i_send  in  1  request to send; sampled only in IDLE.
- i_dst_ip  in  32  destination IP; sampled with i_send.
- i_segment_len_b  in  16  segment length in bytes; sampled with i_send.
- i_segment_type  in  8  protocol: 8'h06 TCP, 8'h11 UDP; sampled with i_send.
- o_seg_rd  out  1  payload byte consumed this cycle.
- i_seg_data  in  `FPGA_DATA_WIDTH  payload byte. First-word-fall-through: valid whenever o_seg_rd is high.
- i_mac_ready  in  1  MAC accepts o_ip_data this cycle.
- o_ip_valid  out  1  o_ip_data is valid.
- o_ip_data  out  `FPGA_DATA_WIDTH  datagram byte.
- o_ip_last  out  1  marks the final datagram byte.
- o_ip_tx_busy  out  1  high whenever state is not IDLE.
- o_drop  out  1  one-cycle pulse when a request is rejected.

## Operation
- States: IDLE, CSUM, HEADER, PAYLOAD.
- **IDLE**, when i_send=1:
  - If length is 0, or length > MAX_SEG_LEN, or type is neither 8'h06 nor 8'h11: pulse o_drop next cycle and stay in IDLE.
  - Otherwise latch dst, len, type and the current id_cnt, increment id_cnt (16-bit, wraps FFFF→0000), and go to CSUM.
- Header bytes 0..19:
  - 45, 00, total_len[15:8], total_len[7:0], id[15:8], id[7:0], 40, 00, TTL, type, csum[15:8], csum[7:0], src[31:0] MSB first, dst[31:0] MSB first.
  - total_len = len + 20, computed 16-bit.
- **CSUM**, 10 cycles:
  - Each cycle adds one 16-bit header word (words 0..9, with the checksum word taken as 0000) into a 17-bit accumulator with end-around carry.
  - After word 9: csum = ~sum[15:0]. Go to HEADER.
- **HEADER**: emit bytes 0..19 via a byte counter, advancing only on an output load.
- **PAYLOAD**: emit len bytes from i_seg_data. Payload counter is 16 bits. o_ip_last is set with the byte where count == len-1. Return to IDLE when that byte is loaded.
- Output register:
  - Loads when (~o_ip_valid | i_mac_ready).
  - While o_ip_valid=1 and i_mac_ready=0: o_ip_data, o_ip_last and o_ip_valid hold, and no counter advances.
- o_seg_rd = (state==PAYLOAD) & (~o_ip_valid | i_mac_ready), combinational. Exactly len pulses per datagram.
- After the last byte is loaded the FSM returns to IDLE; o_ip_valid drops once that byte is accepted, unless a new load occurs.
- i_send while busy: ignored, no o_drop.
- Reset (async, including mid-packet): state IDLE, id_cnt 0000, all counters 0, all outputs 0. A partially sent datagram is abandoned and o_ip_last is never emitted for it.

## Timing
- i_send sampled at edge E0 (IDLE) → CSUM occupies edges E1..E10 → HEADER from E10 → byte 0 registered at E11.
- o_ip_valid first high after E11: 11-cycle latency from the sampling edge.
- With i_mac_ready held 1: one byte per cycle, no bubbles between header and payload.
  - Datagram occupies len+20 consecutive valid cycles.
  - o_ip_tx_busy falls the cycle after the last byte is loaded.
- Earliest next i_send acceptance: the cycle after returning to IDLE; no throughput requirement beyond that.
- o_drop: registered, high for exactly the cycle after the rejected i_send.

## Test plan
- **UDP basic** (`FPGA_IP = C0A8010A): dst C0A80101, len 8, type 11, ready=1, id_cnt=0.
  - Required output: 45 00 00 1C 00 00 40 00 40 11 B7 75 C0 A8 01 0A C0 A8 01 01, then the 8 payload bytes unchanged.
  - o_ip_last on byte 27; first valid 11 cycles after i_send.
- **Backpressure**: same packet with i_mac_ready toggling in a 1/0 pattern plus a 5-cycle stall during payload.
  - Byte stream identical to the basic case; o_seg_rd pulses exactly 8 times; no data change while stalled.
- **Reject**: len 0, len 1481, type 01 (each separately).
  - o_drop pulse for each, o_ip_valid never asserts, id_cnt unchanged.
  - len 1480 is accepted: total_len 05DC, 1500 bytes out.
- **ID wrap**: force id_cnt to FFFF and send two packets.
  - ID field FFFF then 0000; checksums match a reference model.
- **Reset mid-payload**: assert i_rstn=0 at payload byte 3.
  - All outputs 0 immediately, busy 0; the next request starts a clean datagram with id 0000.
- **Busy request**: pulse i_send during HEADER.
  - Ignored: no o_drop, current datagram unaffected, id_cnt incremented only once.

Source files
------------

// File: rtl/ip_tx.sv
// ip_tx: byte-serial IPv4 transmitter. Builds a 20-byte option-less IPv4
// header (DF set, source FPGA_IP) with a computed checksum, then streams
// header and payload bytes to the MAC under ready backpressure.

`ifndef FPGA_IP
`define FPGA_IP 32'hC0A8010A
`endif
`ifndef FPGA_DATA_WIDTH
`define FPGA_DATA_WIDTH 8
`endif

module ip_tx #(
    parameter logic [7:0]  TTL         = 8'd64,
    parameter logic [15:0] MAX_SEG_LEN = 16'd1480
) (
    input  logic                        i_sys_clk,
    input  logic                        i_rstn,
    input  logic                        i_send,
    input  logic [31:0]                 i_dst_ip,
    input  logic [15:0]                 i_segment_len_b,
    input  logic [7:0]                  i_segment_type,
    output logic                        o_seg_rd,
    input  logic [`FPGA_DATA_WIDTH-1:0] i_seg_data,
    input  logic                        i_mac_ready,
    output logic                        o_ip_valid,
    output logic [`FPGA_DATA_WIDTH-1:0] o_ip_data,
    output logic                        o_ip_last,
    output logic                        o_ip_tx_busy,
    output logic                        o_drop
);

    localparam logic [31:0] SRC_IP        = `FPGA_IP;
    localparam logic [3:0]  LAST_WORD     = 4'd9;
    localparam logic [4:0]  LAST_HDR_BYTE = 5'd19;

    typedef enum logic [1:0] {
        IDLE,
        CSUM,
        HEADER,
        PAYLOAD
    } state_t;

    state_t state, state_nxt;

    logic [31:0] dst_q;
    logic [15:0] len_q;
    logic [7:0]  type_q;
    logic [15:0] id_q;
    logic [15:0] id_cnt;
    logic [15:0] csum_q;
    logic [3:0]  word_cnt;
    logic [16:0] acc;
    logic [4:0]  byte_cnt;
    logic [15:0] pay_cnt;
    logic        drop_q;

    logic        req_ok;
    logic        accept;
    logic        reject;
    logic        out_ld;
    logic        pay_last;
    logic [15:0] total_len;
    logic [15:0] hdr_word;
    logic [16:0] acc_sum;
    logic [16:0] fold1;
    logic [15:0] fold2;
    logic [7:0]  hdr_byte;

    assign req_ok    = (i_segment_len_b != 16'd0) &&
                       (i_segment_len_b <= MAX_SEG_LEN) &&
                       ((i_segment_type == 8'h06) || (i_segment_type == 8'h11));
    assign accept    = (state == IDLE) && i_send && req_ok;
    assign reject    = (state == IDLE) && i_send && !req_ok;
    assign total_len = len_q + 16'd20;
    assign pay_last  = (pay_cnt == len_q - 16'd1);
    assign o_drop    = drop_q;

    // Header word fed to the checksum adder, checksum word itself taken as zero
    always_comb begin
        hdr_word = '0;
        case (word_cnt)
            4'd0:    hdr_word = 16'h4500;
            4'd1:    hdr_word = total_len;
            4'd2:    hdr_word = id_q;
            4'd3:    hdr_word = 16'h4000;
            4'd4:    hdr_word = {TTL, type_q};
            4'd5:    hdr_word = 16'h0000;
            4'd6:    hdr_word = SRC_IP[31:16];
            4'd7:    hdr_word = SRC_IP[15:0];
            4'd8:    hdr_word = dst_q[31:16];
            4'd9:    hdr_word = dst_q[15:0];
            default: hdr_word = '0;
        endcase
    end

    // One's-complement add with end-around carry; the final value is folded
    // twice so a carry produced by the fold itself is not lost
    always_comb begin
        acc_sum = {1'b0, acc[15:0]} + {16'b0, acc[16]} + {1'b0, hdr_word};
        fold1   = {1'b0, acc_sum[15:0]} + {16'b0, acc_sum[16]};
        fold2   = fold1[15:0] + {15'b0, fold1[16]};
    end

    // Header byte selected by the output byte counter
    always_comb begin
        hdr_byte = '0;
        case (byte_cnt)
            5'd0:    hdr_byte = 8'h45;
            5'd1:    hdr_byte = 8'h00;
            5'd2:    hdr_byte = total_len[15:8];
            5'd3:    hdr_byte = total_len[7:0];
            5'd4:    hdr_byte = id_q[15:8];
            5'd5:    hdr_byte = id_q[7:0];
            5'd6:    hdr_byte = 8'h40;
            5'd7:    hdr_byte = 8'h00;
            5'd8:    hdr_byte = TTL;
            5'd9:    hdr_byte = type_q;
            5'd10:   hdr_byte = csum_q[15:8];
            5'd11:   hdr_byte = csum_q[7:0];
            5'd12:   hdr_byte = SRC_IP[31:24];
            5'd13:   hdr_byte = SRC_IP[23:16];
            5'd14:   hdr_byte = SRC_IP[15:8];
            5'd15:   hdr_byte = SRC_IP[7:0];
            5'd16:   hdr_byte = dst_q[31:24];
            5'd17:   hdr_byte = dst_q[23:16];
            5'd18:   hdr_byte = dst_q[15:8];
            5'd19:   hdr_byte = dst_q[7:0];
            default: hdr_byte = '0;
        endcase
    end

    // State register
    always_ff @(posedge i_sys_clk or negedge i_rstn) begin
        if (!i_rstn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CSUM;
            CSUM:    if (word_cnt == LAST_WORD) state_nxt = HEADER;
            HEADER:  if (out_ld && (byte_cnt == LAST_HDR_BYTE)) state_nxt = PAYLOAD;
            PAYLOAD: if (out_ld && pay_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output-side strobes: register load enable, payload read, busy
    always_comb begin
        out_ld       = ~o_ip_valid | i_mac_ready;
        o_seg_rd     = (state == PAYLOAD) & out_ld;
        o_ip_tx_busy = (state != IDLE);
    end

    // Request latch, datagram ID counter, checksum accumulation and reject pulse
    always_ff @(posedge i_sys_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            dst_q    <= '0;
            len_q    <= '0;
            type_q   <= '0;
            id_q     <= '0;
            id_cnt   <= '0;
            csum_q   <= '0;
            word_cnt <= '0;
            acc      <= '0;
            drop_q   <= 1'b0;
        end else begin
            drop_q <= reject;
            if (accept) begin
                dst_q    <= i_dst_ip;
                len_q    <= i_segment_len_b;
                type_q   <= i_segment_type;
                id_q     <= id_cnt;
                id_cnt   <= id_cnt + 16'd1;
                acc      <= '0;
                word_cnt <= '0;
            end else if (state == CSUM) begin
                acc <= acc_sum;
                if (word_cnt == LAST_WORD) begin
                    csum_q   <= ~fold2;
                    word_cnt <= '0;
                end else begin
                    word_cnt <= word_cnt + 4'd1;
                end
            end
        end
    end

    // Output register; with nothing to load it only retires the accepted byte
    always_ff @(posedge i_sys_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_ip_valid <= 1'b0;
            o_ip_data  <= '0;
            o_ip_last  <= 1'b0;
            byte_cnt   <= '0;
            pay_cnt    <= '0;
        end else if (out_ld) begin
            case (state)
                HEADER: begin
                    o_ip_valid <= 1'b1;
                    o_ip_data  <= hdr_byte;
                    o_ip_last  <= 1'b0;
                    byte_cnt   <= (byte_cnt == LAST_HDR_BYTE) ? 5'd0 : byte_cnt + 5'd1;
                end
                PAYLOAD: begin
                    o_ip_valid <= 1'b1;
                    o_ip_data  <= i_seg_data;
                    o_ip_last  <= pay_last;
                    pay_cnt    <= pay_last ? 16'd0 : pay_cnt + 16'd1;
                end
                default: begin
                    o_ip_valid <= 1'b0;
                    o_ip_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ip_tx.sv
// tb_ip_tx: randomized self-checking bench for ip_tx. Expected datagrams come
// from a header/checksum model built from the IPv4 field rules.

`ifndef FPGA_IP
`define FPGA_IP 32'hC0A8010A
`endif
`ifndef FPGA_DATA_WIDTH
`define FPGA_DATA_WIDTH 8
`endif

module tb_ip_tx;

    localparam int          W   = `FPGA_DATA_WIDTH;
    localparam logic [31:0] SRC = `FPGA_IP;

    logic         clk       = 1'b0;
    logic         rstn      = 1'b0;
    logic         send      = 1'b0;
    logic [31:0]  dst_ip    = '0;
    logic [15:0]  seg_len   = '0;
    logic [7:0]   seg_type  = '0;
    logic         seg_rd;
    logic [W-1:0] seg_data;
    logic         mac_ready = 1'b1;
    logic         ip_valid;
    logic [W-1:0] ip_data;
    logic         ip_last;
    logic         busy;
    logic         drop;

    ip_tx #(.TTL(8'd64), .MAX_SEG_LEN(16'd1480)) dut (
        .i_sys_clk       (clk),
        .i_rstn          (rstn),
        .i_send          (send),
        .i_dst_ip        (dst_ip),
        .i_segment_len_b (seg_len),
        .i_segment_type  (seg_type),
        .o_seg_rd        (seg_rd),
        .i_seg_data      (seg_data),
        .i_mac_ready     (mac_ready),
        .o_ip_valid      (ip_valid),
        .o_ip_data       (ip_data),
        .o_ip_last       (ip_last),
        .o_ip_tx_busy    (busy),
        .o_drop          (drop)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // First-word-fall-through payload source
    logic [7:0] pay_mem [4096];
    int rd_idx = 0;
    assign seg_data = pay_mem[rd_idx % 4096];
    always @(posedge clk) if (seg_rd) rd_idx <= rd_idx + 1;

    // Output monitor: records accepted bytes, counts stalls and hold violations
    logic [7:0] got_data [4096];
    logic       got_last [4096];
    int         got_n      = 0;
    int         hold_viol  = 0;
    int         stall_seen = 0;
    logic       prev_stall = 1'b0;
    logic [W+1:0] prev_out = '0;
    always @(negedge clk) begin
        if (prev_stall && ({ip_valid, ip_last, ip_data} != prev_out)) hold_viol++;
        if (ip_valid && !mac_ready) stall_seen++;
        prev_stall = ip_valid && !mac_ready && rstn;
        prev_out   = {ip_valid, ip_last, ip_data};
        if (ip_valid && mac_ready) begin
            got_data[got_n % 4096] = ip_data;
            got_last[got_n % 4096] = ip_last;
            got_n++;
        end
    end

    // MAC ready pattern: 0 always ready, 1 random, 2 toggling plus one 5-cycle stall
    int rdy_mode     = 0;
    int pkt_base_out = 0;
    int stall_base   = -1;
    int stall_left   = 0;
    int cyc          = 0;
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        case (rdy_mode)
            0: mac_ready = 1'b1;
            1: mac_ready = (($urandom % 3) != 0);
            default: begin
                if (stall_left > 0) begin
                    mac_ready = 1'b0;
                    stall_left--;
                end else if ((stall_base != pkt_base_out) && (got_n - pkt_base_out >= 23)) begin
                    stall_base = pkt_base_out;
                    stall_left = 4;
                    mac_ready  = 1'b0;
                end else begin
                    mac_ready = cyc[0];
                end
            end
        endcase
    end

    // Reference header: fields laid out by rule, checksum by plain integer sum and fold
    function automatic void build_hdr(input logic [31:0] d, input logic [15:0] l,
                                      input logic [7:0] t, input logic [15:0] id,
                                      output logic [7:0] h [20]);
        logic [15:0] tl;
        logic [15:0] cs;
        int unsigned sum;
        tl  = l + 16'd20;
        sum = 32'h4500 + tl + id + 32'h4000 + {16'h0, 8'd64, t}
              + SRC[31:16] + SRC[15:0] + d[31:16] + d[15:0];
        while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
        cs = ~sum[15:0];
        h = '{8'h45, 8'h00, tl[15:8], tl[7:0], id[15:8], id[7:0], 8'h40, 8'h00,
              8'd64, t, cs[15:8], cs[7:0], SRC[31:24], SRC[23:16], SRC[15:8], SRC[7:0],
              d[31:24], d[23:16], d[15:8], d[7:0]};
    endfunction

    logic [15:0] model_id = '0;

    // Issue one request and check the datagram (or the rejection) it produces
    task automatic send_req(input logic [31:0] d, input logic [15:0] l,
                            input logic [7:0] t, input bit poke);
        bit ok;
        bit seen;
        int base_in;
        int n;
        int lat;
        logic [7:0] h [20];
        ok = (l != 16'd0) && (l <= 16'd1480) && ((t == 8'h06) || (t == 8'h11));
        lat = 0;
        while (busy && lat < 5000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("idle_before_send", {31'b0, busy}, 0);
        base_in      = rd_idx;
        pkt_base_out = got_n;
        if (ok) for (int k = 0; k < int'(l); k++) pay_mem[(base_in + k) % 4096] = 8'($urandom);
        dst_ip   = d;
        seg_len  = l;
        seg_type = t;
        send     = 1'b1;
        @(posedge clk);
        #1;
        send = 1'b0;
        if (!ok) begin
            check("drop_pulse", {31'b0, drop}, 1);
            @(posedge clk);
            #1;
            check("drop_width", {31'b0, drop}, 0);
            seen = 1'b0;
            repeat (15) begin
                if (ip_valid || busy || drop) seen = 1'b1;
                @(posedge clk);
                #1;
            end
            check("reject_quiet", {31'b0, seen}, 0);
            check("reject_no_read", rd_idx - base_in, 0);
            return;
        end
        check("busy_after_accept", {31'b0, busy}, 1);
        check("no_drop_on_accept", {31'b0, drop}, 0);
        lat = 0;
        while (!ip_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("first_valid_latency", lat, 11);
        if (poke) begin
            send = 1'b1;
            @(posedge clk);
            #1;
            send = 1'b0;
            check("busy_send_no_drop", {31'b0, drop}, 0);
        end
        n   = int'(l) + 20;
        lat = 0;
        while ((got_n - pkt_base_out < n) && (lat < 20 * n + 200)) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("byte_count", got_n - pkt_base_out, n);
        check("valid_after_last", {31'b0, ip_valid}, 0);
        check("busy_after_last", {31'b0, busy}, 0);
        check("seg_rd_count", rd_idx - base_in, int'(l));
        build_hdr(d, l, t, model_id, h);
        for (int i = 0; i < n; i++) begin
            logic [7:0] e;
            e = (i < 20) ? h[i] : pay_mem[(base_in + i - 20) % 4096];
            check($sformatf("byte%0d", i), {24'b0, got_data[(pkt_base_out + i) % 4096]}, {24'b0, e});
            check($sformatf("last%0d", i), {31'b0, got_last[(pkt_base_out + i) % 4096]},
                  (i == n - 1) ? 32'd1 : 32'd0);
        end
        model_id = model_id + 16'd1;
    endtask

    logic [7:0] basic_hdr [20] = '{8'h45, 8'h00, 8'h00, 8'h1C, 8'h00, 8'h00, 8'h40, 8'h00,
                                   8'h40, 8'h11, 8'hB7, 8'h75, 8'hC0, 8'hA8, 8'h01, 8'h0A,
                                   8'hC0, 8'hA8, 8'h01, 8'h01};

    initial begin
        int stall0;
        int lat;
        int base_rst;
        logic [15:0] rl;
        logic [7:0]  rt;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs", {26'b0, ip_valid, ip_last, busy, drop, seg_rd, 1'b0}, 0);
        check("rst_data", {24'b0, ip_data}, 0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // UDP basic, checked also against the literal byte stream
        rdy_mode = 0;
        send_req(32'hC0A80101, 16'd8, 8'h11, 1'b0);
        for (int i = 0; i < 20; i++)
            check($sformatf("basic_hdr%0d", i), {24'b0, got_data[(pkt_base_out + i) % 4096]},
                  {24'b0, basic_hdr[i]});

        // Backpressure
        rdy_mode = 2;
        stall0   = stall_seen;
        send_req(32'hC0A80101, 16'd8, 8'h11, 1'b0);
        check("stall_cycles_seen", {31'b0, (stall_seen - stall0) >= 5}, 1);
        check("stall_hold", hold_viol, 0);
        rdy_mode = 0;

        // Rejects, then the largest accepted segment
        send_req(32'h0A000001, 16'd0,    8'h11, 1'b0);
        send_req(32'h0A000001, 16'd1481, 8'h11, 1'b0);
        send_req(32'h0A000001, 16'd100,  8'h01, 1'b0);
        send_req(32'h0A000002, 16'd1480, 8'h06, 1'b0);
        check("max_total_len", {16'b0, got_data[(pkt_base_out + 2) % 4096], got_data[(pkt_base_out + 3) % 4096]},
              32'h05DC);

        // Request while busy is ignored; the next datagram takes the next id
        send_req(32'h0A000003, 16'd12, 8'h11, 1'b1);
        send_req(32'h0A000004, 16'd5,  8'h06, 1'b0);

        // ID wrap
        force dut.id_cnt = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.id_cnt;
        model_id = 16'hFFFF;
        send_req(32'h0A000005, 16'd9, 8'h11, 1'b0);
        send_req(32'h0A000006, 16'd7, 8'h06, 1'b0);
        check("id_after_wrap", {16'b0, got_data[(pkt_base_out + 4) % 4096], got_data[(pkt_base_out + 5) % 4096]}, 0);

        // Reset while payload byte 3 is on the output
        dst_ip       = 32'h0A000007;
        seg_len      = 16'd20;
        seg_type     = 8'h11;
        pkt_base_out = got_n;
        base_rst     = rd_idx;
        for (int k = 0; k < 20; k++) pay_mem[(base_rst + k) % 4096] = 8'($urandom);
        send = 1'b1;
        @(posedge clk);
        #1;
        send = 1'b0;
        lat  = 0;
        while ((got_n - pkt_base_out < 23) && (lat < 200)) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("reached_payload3", got_n - pkt_base_out, 23);
        rstn = 1'b0;
        #1;
        check("midrst_outputs", {26'b0, ip_valid, ip_last, busy, drop, seg_rd, 1'b0}, 0);
        check("midrst_data", {24'b0, ip_data}, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("midrst_no_last", {31'b0, got_last[(got_n + 4095) % 4096]}, 0);
        rstn     = 1'b1;
        model_id = '0;
        @(posedge clk);
        #1;
        send_req(32'h0A000008, 16'd6, 8'h11, 1'b0);

        // Randomized traffic
        for (int r = 0; r < 14; r++) begin
            rdy_mode = int'($urandom_range(0, 2));
            case ($urandom_range(0, 5))
                0: send_req($urandom, 16'd0, 8'h11, 1'b0);
                1: begin
                    rl = 16'($urandom_range(1481, 65535));
                    send_req($urandom, rl, 8'h06, 1'b0);
                end
                2: begin
                    rt = 8'($urandom);
                    if (rt == 8'h06 || rt == 8'h11) rt = 8'h01;
                    send_req($urandom, 16'($urandom_range(1, 40)), rt, 1'b0);
                end
                default: begin
                    rl = 16'($urandom_range(1, 48));
                    rt = ($urandom % 2) ? 8'h06 : 8'h11;
                    send_req($urandom, rl, rt, 1'b0);
                end
            endcase
        end
        rdy_mode = 0;
        check("hold_overall", hold_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
